// File: rtl/layer_stream_driver.sv
// Host-side harness for one layer: streams V input vectors of N elements to the
// layer's slave port and collects V*M results from its master port.
module layer_stream_driver #(
    parameter int unsigned N = 8,
    parameter int unsigned M = 6,
    parameter int unsigned T = 16,
    parameter int unsigned V = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ld_en,
    input  logic [$clog2(V*N)-1:0]    ld_addr,
    input  logic [T-1:0]              ld_data,
    input  logic                      start,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [T-1:0]              m_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [T-1:0]              s_data,
    input  logic [$clog2(V*M)-1:0]    rd_addr,
    output logic [T-1:0]              rd_data,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned NT  = V * N;
    localparam int unsigned NR  = V * M;
    localparam int unsigned IAW = $clog2(NT);
    localparam int unsigned RAW = $clog2(NR);
    localparam int unsigned TW  = $clog2(NT + 1);
    localparam int unsigned RW  = $clog2(NR + 1);

    localparam logic [TW-1:0] TX_LAST = TW'(NT - 1);
    localparam logic [RW-1:0] RX_LAST = RW'(NR - 1);
    localparam logic [TW-1:0] LD_LIM  = TW'(NT);
    localparam logic [RW-1:0] RD_LIM  = RW'(NR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [T-1:0]   inbuf  [NT];
    logic [T-1:0]   resbuf [NR];

    logic [TW-1:0]  tx_idx;
    logic [RW-1:0]  rx_idx;
    logic [IAW-1:0] tx_nxt;
    logic           tx_hs;
    logic           rx_hs;
    logic           rx_last;
    logic           ld_ok;
    logic           rd_ok;

    assign tx_hs   = m_valid & m_ready;
    assign rx_hs   = s_valid & s_ready;
    assign rx_last = (rx_idx == RX_LAST);
    assign tx_nxt  = tx_idx[IAW-1:0] + IAW'(1);
    // Widen addresses before the range test so the limit is representable.
    assign ld_ok   = (TW'(ld_addr) < LD_LIM);
    assign rd_ok   = (RW'(rd_addr) < RD_LIM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (rx_hs && rx_last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_idx  <= '0;
            rx_idx  <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_idx  <= '0;
                        rx_idx  <= '0;
                        m_valid <= 1'b1;
                        m_data  <= inbuf[0];
                        s_ready <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (tx_hs) begin
                        tx_idx <= tx_idx + TW'(1);
                        if (tx_idx == TX_LAST) begin
                            m_valid <= 1'b0;
                        end else begin
                            m_data <= inbuf[tx_nxt];
                        end
                    end
                    if (rx_hs) begin
                        rx_idx <= rx_idx + RW'(1);
                        // Last result closes the run even if TX is still pending.
                        if (rx_last) begin
                            s_ready <= 1'b0;
                            m_valid <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && ld_en && ld_ok) begin
            inbuf[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (state == RUN && rx_hs) begin
            resbuf[rx_idx[RAW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_ok ? resbuf[rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_layer_stream_driver.sv
// Randomized bench for layer_stream_driver: a transfer-count model predicts every
// output each cycle, with literal expectations for the directed streaming runs.
module tb_layer_stream_driver;

    localparam int N   = 8;
    localparam int M   = 6;
    localparam int T   = 16;
    localparam int V   = 4;
    localparam int NT  = V * N;
    localparam int NR  = V * M;
    localparam int IAW = $clog2(NT);
    localparam int RAW = $clog2(NR);

    logic           clk;
    logic           reset;
    logic           ld_en;
    logic [IAW-1:0] ld_addr;
    logic [T-1:0]   ld_data;
    logic           start;
    logic           m_valid;
    logic           m_ready;
    logic [T-1:0]   m_data;
    logic           s_valid;
    logic           s_ready;
    logic [T-1:0]   s_data;
    logic [RAW-1:0] rd_addr;
    logic [T-1:0]   rd_data;
    logic           busy;
    logic           done;

    layer_stream_driver #(.N(N), .M(M), .T(T), .V(V)) dut (
        .clk(clk), .reset(reset),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffers plus transfer counts of the current run
    logic [T-1:0] in_m  [NT];
    logic [T-1:0] res_m [NR];
    bit           res_known [NR];
    bit           e_busy, e_done, e_rd_known;
    logic [T-1:0] e_rd;
    int           tx_cnt, rx_cnt;
    int           cyc, done_cnt, done_cyc;
    int           tx_hs_n, rx_hs_n, first_tx, last_tx, last_rx;

    always @(negedge clk) begin
        bit mv_e, sr_e, was_done;
        cyc++;
        if (!reset) begin
            chk("rst_m_valid", 32'(m_valid), 32'(0));
            chk("rst_m_data",  32'(m_data),  32'(0));
            chk("rst_s_ready", 32'(s_ready), 32'(0));
            chk("rst_busy",    32'(busy),    32'(0));
            chk("rst_done",    32'(done),    32'(0));
            chk("rst_rd_data", 32'(rd_data), 32'(0));
            e_busy = 0; e_done = 0; tx_cnt = 0; rx_cnt = 0;
            e_rd = '0; e_rd_known = 1;
        end else begin
            mv_e = e_busy && (tx_cnt < NT);
            sr_e = e_busy && (rx_cnt < NR);
            chk("m_valid", 32'(m_valid), 32'(mv_e));
            if (mv_e) chk("m_data", 32'(m_data), 32'(in_m[IAW'(tx_cnt)]));
            chk("s_ready", 32'(s_ready), 32'(sr_e));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            if (e_rd_known) chk("rd_data", 32'(rd_data), 32'(e_rd));
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            e_rd       = res_m[rd_addr];
            e_rd_known = res_known[rd_addr];
            was_done   = e_done;
            e_done     = 0;
            if (e_busy) begin
                if (mv_e && m_ready) begin
                    if (tx_hs_n == 0) first_tx = cyc;
                    last_tx = cyc;
                    tx_hs_n++;
                    tx_cnt++;
                end
                if (sr_e && s_valid) begin
                    res_m[RAW'(rx_cnt)]     = s_data;
                    res_known[RAW'(rx_cnt)] = 1;
                    rx_cnt++;
                    rx_hs_n++;
                    last_rx = cyc;
                    if (rx_cnt == NR) begin
                        e_busy = 0;
                        e_done = 1;
                    end
                end
            end else if (!was_done) begin
                if (ld_en) in_m[ld_addr] = ld_data;
                if (start) begin
                    e_busy = 1; tx_cnt = 0; rx_cnt = 0;
                end
            end
        end
    end

    // Responder only offers results for vectors already fully sent.
    int mode;
    int pat;
    bit rd_rand;
    bit poke_done;

    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0;
        ld_en = 1'b0;
        if (poke_done && done) start = 1'b1;
        pat++;
        case (mode)
            0: begin m_ready = 1'b1; s_valid = 1'b1; s_data = T'(10 + rx_cnt); end
            1: begin
                m_ready = 1'($urandom_range(0, 1));
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = T'($urandom);
            end
            default: begin
                m_ready = (pat % 3 == 0);
                s_valid = (pat % 4 != 1);
                s_data  = T'(10 + rx_cnt);
            end
        endcase
        if (rx_cnt >= (tx_cnt / N) * M) s_valid = 1'b0;
        if (rd_rand) rd_addr = RAW'($urandom_range(0, NR - 1));
    endtask

    task automatic load(input int a, input logic [T-1:0] d);
        ld_en = 1'b1; ld_addr = IAW'(a); ld_data = d;
        tick();
    endtask

    task automatic start_run();
        tx_hs_n = 0; rx_hs_n = 0;
        start = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 3000 && done_cnt == d0; i++) tick();
        if (done_cnt == d0) chk("run_timeout", 32'(0), 32'(1));
        repeat (3) tick();
    endtask

    task automatic readback_lit(input string name);
        rd_rand = 0;
        for (int a = 0; a < M; a++) begin
            rd_addr = RAW'(a);
            tick();
            chk(name, 32'(rd_data), 32'(10 + a));
        end
        rd_addr = RAW'(NR - 1);
        tick();
        chk(name, 32'(rd_data), 32'(10 + NR - 1));
    endtask

    initial begin
        int d0;
        reset = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0;
        m_ready = 1'b0; s_valid = 1'b0; s_data = '0; rd_addr = '0;
        mode = 0; pat = 0; rd_rand = 0; poke_done = 0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_m_valid", 32'(m_valid), 32'(0));

        for (int a = 0; a < NT; a++) load(a, T'(a + 1));

        // Full-rate streaming
        d0 = done_cnt;
        mode = 0;
        start_run();
        chk("first_m_data", 32'(m_data), 32'(1));
        chk("first_m_valid", 32'(m_valid), 32'(1));
        wait_done(d0);
        chk("tx_count", 32'(tx_hs_n), 32'(32));
        chk("rx_count", 32'(rx_hs_n), 32'(24));
        chk("tx_no_bubble", 32'(last_tx - first_tx), 32'(31));
        chk("done_latency", 32'(done_cyc - last_rx), 32'(1));
        chk("done_once", 32'(done_cnt - d0), 32'(1));
        readback_lit("rd_lit_fullrate");

        // Backpressure on both sides
        d0 = done_cnt;
        mode = 2;
        start_run();
        wait_done(d0);
        chk("bp_tx_count", 32'(tx_hs_n), 32'(32));
        chk("bp_rx_count", 32'(rx_hs_n), 32'(24));
        chk("bp_done_once", 32'(done_cnt - d0), 32'(1));
        readback_lit("rd_lit_backpressure");

        // Start and load requests issued mid-run are ignored
        d0 = done_cnt;
        mode = 1;
        start_run();
        repeat (5) tick();
        start = 1'b1; ld_en = 1'b1; ld_addr = '0; ld_data = 16'h7FFF;
        tick();
        wait_done(d0);
        chk("ignored_done_once", 32'(done_cnt - d0), 32'(1));
        d0 = done_cnt;
        mode = 0;
        start_run();
        chk("inbuf0_kept", 32'(m_data), 32'(1));
        wait_done(d0);

        // Start in the done cycle is ignored
        d0 = done_cnt;
        poke_done = 1;
        start_run();
        wait_done(d0);
        poke_done = 0;
        chk("start_in_done_busy", 32'(busy), 32'(0));
        chk("start_in_done_once", 32'(done_cnt - d0), 32'(1));

        // Abort after the third element transfer
        d0 = done_cnt;
        start_run();
        for (int i = 0; i < 100 && tx_hs_n < 3; i++) tick();
        chk("abort_reach", 32'(tx_hs_n >= 3), 32'(1));
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_m_valid", 32'(m_valid), 32'(0));
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        start_run();
        chk("restart_m_data", 32'(m_data), 32'(1));
        wait_done(d0);
        chk("restart_tx_count", 32'(tx_hs_n), 32'(32));

        // Random data, random handshakes, random reads
        for (int a = 0; a < NT; a++) load(a, T'($urandom));
        mode = 1;
        rd_rand = 1;
        for (int r = 0; r < 3; r++) begin
            d0 = done_cnt;
            start_run();
            wait_done(d0);
        end
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
